// File: rtl/bitwise_seq.sv
// Multi-byte sequencer around the 8-bit bitwise ALU slice.
// A command (op, invc, cin, len) streams len operand byte pairs through the
// slice and returns one result byte per pair. Depending on the op it either
// chains the carry through the bytes or accumulates zero/parity flags, and it
// reports one final flag when the command completes.

// 8-bit bitwise ALU slice.
//   op=00: q = a & b,    flag = cin & op[0] (= 0)
//   op=01: q = a | b,    flag = cin & op[0] (= cin, carry passes through)
//   op=10: q = a ^ b,    flag = (a == 0)
//   op=11: q = ~(a ^ b), flag = odd parity of a
// cout is the flag optionally inverted by invc.
module bitwise (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    input  logic       cin,
    input  logic       invc,
    output logic [7:0] q,
    output logic       cout
);

    // Odd parity of a byte: 1 when the number of set bits is odd.
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    logic flag_raw;

    // Byte result and per-byte flag selected by the op code.
    always_comb begin
        q        = 8'h00;
        flag_raw = 1'b0;
        case (op)
            2'b00: begin
                q        = a & b;
                flag_raw = cin & op[0];
            end
            2'b01: begin
                q        = a | b;
                flag_raw = cin & op[0];
            end
            2'b10: begin
                q        = a ^ b;
                flag_raw = (a == 8'h00);
            end
            2'b11: begin
                q        = ~(a ^ b);
                flag_raw = parity8(a);
            end
            default: begin
                q        = 8'h00;
                flag_raw = 1'b0;
            end
        endcase
        cout = flag_raw ^ invc;
    end

endmodule

module bitwise_seq #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_invc,
    input  logic             cmd_cin,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             opnd_valid,
    output logic             opnd_ready,
    input  logic [7:0]       opnd_a,
    input  logic [7:0]       opnd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_q,
    output logic             res_last,
    output logic             done,
    output logic             flag_out,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       op_r;
    logic             invc_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] cnt_r;
    logic             carry_r;
    logic             acc_r;
    logic             illegal_r;

    logic [7:0]       slice_q_s;
    logic             slice_cout_s;
    logic             out_free_s;
    logic             res_hs_s;
    logic             opnd_hs_s;
    logic             cmd_hs_s;
    logic             last_byte_s;
    logic             len_legal_s;
    logic             acc_next_s;

    // The slice always sees the raw flag; the final inversion is applied once
    // at the end of the command.
    bitwise u_slice (
        .a    (opnd_a),
        .b    (opnd_b),
        .op   (op_r),
        .cin  (carry_r),
        .invc (1'b0),
        .q    (slice_q_s),
        .cout (slice_cout_s)
    );

    // Handshake decode; the output register can take a new byte when it is
    // empty or is being drained this cycle. cmd_ready stays low during the
    // done cycle so the next command starts in the cycle after done.
    always_comb begin
        out_free_s  = ~res_valid | res_ready;
        res_hs_s    = res_valid & res_ready;
        if (state == S_RUN) begin
            opnd_ready = out_free_s;
        end else begin
            opnd_ready = 1'b0;
        end
        opnd_hs_s   = opnd_valid & opnd_ready;
        cmd_ready   = (state == S_IDLE) & ~done;
        cmd_hs_s    = cmd_valid & cmd_ready;
        last_byte_s = (cnt_r == (len_r - LEN_W'(1)));
        len_legal_s = (cmd_len != {LEN_W{1'b0}}) && (cmd_len <= LEN_W'(MAX_LEN));
        if (op_r[0]) begin
            acc_next_s = acc_r ^ slice_cout_s;
        end else begin
            acc_next_s = acc_r & slice_cout_s;
        end
    end

    // Command sequencer: latch the command, stream bytes, report the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= 2'b00;
            invc_r    <= 1'b0;
            len_r     <= {LEN_W{1'b0}};
            cnt_r     <= {LEN_W{1'b0}};
            carry_r   <= 1'b0;
            acc_r     <= 1'b0;
            illegal_r <= 1'b0;
            res_valid <= 1'b0;
            res_q     <= 8'h00;
            res_last  <= 1'b0;
            done      <= 1'b0;
            flag_out  <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (res_hs_s) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_hs_s) begin
                        op_r      <= cmd_op;
                        invc_r    <= cmd_invc;
                        len_r     <= cmd_len;
                        carry_r   <= cmd_cin;
                        acc_r     <= ~cmd_op[0];
                        cnt_r     <= {LEN_W{1'b0}};
                        flag_out  <= 1'b0;
                        illegal_r <= ~len_legal_s;
                        state     <= len_legal_s ? S_RUN : S_FIN;
                    end
                end
                S_RUN: begin
                    if (opnd_hs_s) begin
                        res_q     <= slice_q_s;
                        res_valid <= 1'b1;
                        res_last  <= last_byte_s;
                        carry_r   <= slice_cout_s;
                        acc_r     <= acc_next_s;
                        cnt_r     <= cnt_r + LEN_W'(1);
                        if (last_byte_s) begin
                            state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (out_free_s) begin
                        done  <= 1'b1;
                        err   <= illegal_r;
                        state <= S_IDLE;
                        if (illegal_r) begin
                            flag_out <= 1'b0;
                        end else begin
                            flag_out <= (op_r[1] ? acc_r : carry_r) ^ invc_r;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
